// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit path: FSM state encodings and default
// FIFO geometry, also used by the receive-side buffering.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_DEPTH_LOG2 = 4;
    localparam int DEFAULT_WIDTH      = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

endpackage

// File: rtl/uart_tx_fifo_ram.sv
// FIFO storage: DEPTH x WIDTH, one synchronous write port and one synchronous
// read port whose registered output drives the UART byte directly.
module uart_tx_fifo_ram
    import uart_tx_fifo_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_DEPTH_LOG2,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read register holds the launched byte until the next pop.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: absorbs 1-cycle write strobes and launches one
// byte per uart_tx done pulse. Optional high-water mark via UART_TX_FIFO_HWM_EN.
//
// state  | meaning
// IDLE   | wait for data; pop when not empty
// LAUNCH | tx_dv high for this single cycle
// BUSY   | uart_tx shifting; wait for tx_done
// GAP    | one cycle for uart_tx to return to idle
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_byte,
    input  logic                  in_valid,
    input  logic                  tx_done,
    output logic [WIDTH-1:0]      tx_byte,
    output logic                  tx_dv,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
`ifdef UART_TX_FIFO_HWM_EN
    ,
    output logic [DEPTH_LOG2:0]   hwm
`endif
);

    localparam logic [DEPTH_LOG2:0] LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            state;
    logic                  push;
    logic                  pop;

    assign full  = (level == LEVEL_MAX);
    assign empty = (level == '0);
    assign pop   = (state == ST_IDLE) && !empty;
    // A pop in the same cycle frees the slot the write lands in.
    assign push  = in_valid && (!full || pop);

    uart_tx_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .WIDTH  (WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_byte),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (tx_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (in_valid && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            tx_dv <= 1'b0;
        end else begin
            // Every pop enters LAUNCH, so registering pop gives a one-cycle tx_dv.
            tx_dv <= pop;
            case (state)
                ST_IDLE:   if (pop) state <= ST_LAUNCH;
                ST_LAUNCH: state <= ST_BUSY;
                ST_BUSY:   if (tx_done) state <= ST_GAP;
                ST_GAP:    state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_HWM_EN
    always_ff @(posedge clk) begin
        if (reset)
            hwm <= '0;
        else if (level > hwm)
            hwm <= level;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a monitor
// checks every tx_dv against the queue and the done-to-launch spacing.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef UART_TX_FIFO_HWM_EN
    logic [4:0] hwm;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .tx_done  (tx_done),
        .tx_byte  (tx_byte),
        .tx_dv    (tx_dv),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
`ifdef UART_TX_FIFO_HWM_EN
        ,
        .hwm      (hwm)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dv_count = 0;
    int         busy_len = 4;
    logic       stall = 1'b0;
    logic [7:0] exp_q[$];
    logic       lat_pending = 1'b0;
    int         lat_cycle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consecutive calls give back-to-back strobes.
    task automatic wr1(input logic [7:0] b, input bit accept);
        in_byte  = b;
        in_valid = 1'b1;
        if (accept) exp_q.push_back(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        chk("drain_done", exp_q.size(), 0);
        repeat (busy_len + 4) tick();
    endtask

    // uart_tx model: done pulse busy_len cycles after tx_dv, held off while stalled.
    initial begin
        int n;
        bit abort;
        forever begin
            @(negedge clk);
            if (tx_dv && !reset) begin
                n = 0;
                abort = 0;
                forever begin
                    @(posedge clk);
                    #2;
                    if (reset) begin abort = 1; break; end
                    n++;
                    if ((n >= busy_len && !stall) || n > 20000) break;
                end
                if (!abort) begin
                    tx_done = 1'b1;
                    @(posedge clk);
                    #2;
                    tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                lat_pending = 1'b0;
            end else begin
                if (lat_pending && cyc == lat_cycle + 3) begin
                    chk("done_to_dv_3", tx_dv, 1);
                    lat_pending = 1'b0;
                end
                if (tx_done && exp_q.size() > 0) begin
                    lat_pending = 1'b1;
                    lat_cycle   = cyc;
                end
                if (tx_dv) begin
                    dv_count++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx_dv", {24'h0, tx_byte}, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte_order", tx_byte, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
`ifdef UART_TX_FIFO_HWM_EN
        chk("rst_hwm", hwm, 0);
`endif

        // Test 1: single byte, write at N -> tx_dv at N+2
        tick();
        wr1(8'h41, 1);
        @(negedge clk);
        chk("t1_dv_not_yet", tx_dv, 0);
        @(negedge clk);
        chk("t1_dv_at_n2", tx_dv, 1);
        chk("t1_byte", tx_byte, 8'h41);
        tick();
        drain(200);
        chk("t1_level", level, 0);
        chk("t1_empty", empty, 1);

        // Test 3: full FIFO in IDLE, write coincides with pop
        do_reset();
        stall = 1'b1;
        wr1(8'hAA, 1);
        repeat (3) tick();
        for (int i = 0; i < 16; i++) wr1(8'(i), 1);
        @(negedge clk);
        chk("t3_full", full, 1);
        chk("t3_level_full", level, 16);
        tick();
        stall = 1'b0;
        tick();
        tick();
        in_byte  = 8'h55;
        in_valid = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        chk("t3_level_idle", level, 16);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_level_after", level, 16);
        chk("t3_overflow", overflow, 0);
        chk("t3_full_after", full, 1);
        tick();
        drain(1000);
        chk("t3_overflow_end", overflow, 0);

        // Test 4: 40 bytes through wrapping pointers
        dv0 = dv_count;
        for (int i = 0; i < 4; i++) wr1(8'h80 + 8'(i), 1);
        for (int i = 4; i < 40; i++) begin
            wr1(8'h80 + 8'(i), 1);
            repeat (8) tick();
        end
        drain(1000);
        chk("t4_dv_count", dv_count - dv0, 40);
        chk("t4_overflow", overflow, 0);
        chk("t4_empty", empty, 1);

        // Test 2: fill to 16, 17th write dropped
        stall = 1'b1;
        wr1(8'hAA, 1);
        repeat (3) tick();
        for (int i = 0; i < 16; i++) wr1(8'(i), 1);
        @(negedge clk);
        chk("t2_full", full, 1);
        chk("t2_level", level, 16);
        chk("t2_no_overflow", overflow, 0);
        tick();
        wr1(8'hFF, 0);
        @(negedge clk);
        chk("t2_overflow", overflow, 1);
        chk("t2_level_drop", level, 16);
        tick();
        stall = 1'b0;
        drain(1000);
        chk("t2_overflow_sticky", overflow, 1);
        chk("t2_level_end", level, 0);

        // Test 5: reset while BUSY with 5 queued
        stall = 1'b1;
        wr1(8'h11, 1);
        repeat (3) tick();
        for (int i = 0; i < 5; i++) wr1(8'h22 + 8'(i), 1);
        @(negedge clk);
        chk("t5_level_pre", level, 5);
        chk("t5_overflow_pre", overflow, 1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_level", level, 0);
        chk("t5_tx_dv", tx_dv, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_empty", empty, 1);
        chk("t5_tx_byte", tx_byte, 0);
        stall = 1'b0;
        dv0 = dv_count;
        repeat (30) tick();
        chk("t5_no_dv", dv_count - dv0, 0);
        wr1(8'h77, 1);
        drain(200);
        chk("t5_dv_after_write", dv_count - dv0, 1);

`ifdef UART_TX_FIFO_HWM_EN
        // Test 6: high-water mark
        do_reset();
        tick();
        chk("t6_hwm_rst", hwm, 0);
        stall = 1'b1;
        wr1(8'h01, 1);
        repeat (3) tick();
        for (int i = 0; i < 7; i++) wr1(8'h02 + 8'(i), 1);
        repeat (2) tick();
        chk("t6_hwm7", hwm, 7);
        stall = 1'b0;
        drain(500);
        chk("t6_hwm_hold", hwm, 7);
        chk("t6_empty", empty, 1);
        stall = 1'b1;
        wr1(8'h30, 1);
        repeat (3) tick();
        for (int i = 0; i < 17; i++) wr1(8'h40 + 8'(i), i < 16);
        repeat (2) tick();
        chk("t6_hwm16", hwm, 16);
        stall = 1'b0;
        drain(1000);
        chk("t6_hwm_sat", hwm, 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
